// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_ECH = 1'b0,
        SRC_RES = 1'b1
    } src_t;

    localparam int DEF_DEPTH     = 4;
    localparam int DEF_BUSY_WAIT = 4;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte sources on one side, UART write port on the other.
interface uart_tx_sched_if;

    logic [7:0] ech_data;
    logic       ech_valid;
    logic [7:0] res_data;
    logic       res_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_wr;

    modport master (
        output ech_data, ech_valid, res_data, res_valid, tx_busy,
        input  tx_data, tx_wr
    );

    modport slave (
        input  ech_data, ech_valid, res_data, res_valid, tx_busy,
        output tx_data, tx_wr
    );

endinterface

// File: rtl/uart_tx_sched_byte_fifo.sv
// Small byte FIFO with registered occupancy, synchronous flush and a drop flag
// that reports a push refused because the FIFO was already full.
module byte_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Fullness is judged on the registered count, so a same-cycle pop does not make room.
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign drop    = push && full && !clr;
    assign head    = mem[rd_ptr_q];

    // NOTE: the storage array is deliberately not reset; the empty flag guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between the echo and
// adder-result byte sources, pacing write strobes on the UART busy flag.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BUSY_WAIT = DEF_BUSY_WAIT
) (
    input  logic           clk,
    input  logic           resetq,
    input  logic           clr,
    uart_tx_sched_if.slave bus,
    output logic           ech_ovf,
    output logic           res_ovf,
    output logic           idle
);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    state_t     state_q;
    state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    src_t       last_grant_q;
    src_t       last_grant_d;
    src_t       grant_src;
    logic       grant;
    logic [7:0] grant_data;
    logic [7:0] tx_data_q;
    logic       tx_wr_q;
    logic       ech_ovf_q;
    logic       res_ovf_q;

    logic [7:0] ech_head;
    logic [7:0] res_head;
    logic       ech_empty;
    logic       res_empty;
    logic       ech_drop;
    logic       res_drop;
    logic       pop_ech;
    logic       pop_res;

    byte_fifo #(.DEPTH(DEPTH)) u_ech_fifo (
        .clk       (clk),
        .resetq    (resetq),
        .clr       (clr),
        .push      (bus.ech_valid),
        .push_data (bus.ech_data),
        .pop       (pop_ech),
        .head      (ech_head),
        .empty     (ech_empty),
        .drop      (ech_drop)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_res_fifo (
        .clk       (clk),
        .resetq    (resetq),
        .clr       (clr),
        .push      (bus.res_valid),
        .push_data (bus.res_data),
        .pop       (pop_res),
        .head      (res_head),
        .empty     (res_empty),
        .drop      (res_drop)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;
        grant_src    = SRC_ECH;

        // Both waiting: alternate away from the last winner; otherwise serve whoever has data.
        if (!ech_empty && !res_empty) begin
            grant_src = (last_grant_q == SRC_RES) ? SRC_ECH : SRC_RES;
        end else if (!ech_empty) begin
            grant_src = SRC_ECH;
        end else begin
            grant_src = SRC_RES;
        end

        case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && !(ech_empty && res_empty)) begin
                    grant        = 1'b1;
                    last_grant_d = grant_src;
                    cnt_d        = CW'(BUSY_WAIT);
                    state_d      = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    // A UART that never shows busy is treated as having taken the byte.
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop_ech    = grant && (grant_src == SRC_ECH);
    assign pop_res    = grant && (grant_src == SRC_RES);
    assign grant_data = (grant_src == SRC_ECH) ? ech_head : res_head;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SRC_RES;
            tx_data_q    <= 8'h00;
            tx_wr_q      <= 1'b0;
            ech_ovf_q    <= 1'b0;
            res_ovf_q    <= 1'b0;
        end else if (clr) begin
            // A byte already strobed finishes inside the UART; tx_data is left as it was.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SRC_RES;
            tx_wr_q      <= 1'b0;
            ech_ovf_q    <= 1'b0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            tx_wr_q      <= grant;
            if (grant) begin
                tx_data_q <= grant_data;
            end
            if (ech_drop) begin
                ech_ovf_q <= 1'b1;
            end
            if (res_drop) begin
                res_ovf_q <= 1'b1;
            end
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;
    assign ech_ovf     = ech_ovf_q;
    assign res_ovf     = res_ovf_q;
    assign idle        = (state_q == ST_IDLE) && ech_empty && res_empty;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler that shares the single UART transmitter between two byte sources: the keystroke echo path and the adder-result path. Each source pushes into its own small FIFO; the scheduler grants round-robin, issues one-cycle write strobes to the UART, and paces them on the UART's busy flag so no byte is lost. It sits between the glue/datapath producers and the buart `wr`/`tx_data` inputs, replacing the direct echo/result mux.

## Interface
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `BUSY_WAIT`, 4: cycles to wait for `tx_busy` to rise after a strobe before treating the byte as accepted.
- `clk` input 1: single system clock; all logic on rising edge.
- `resetq` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous flush, active-high (driven from the soft internal reset).
- `ech_data` input 8: echo byte.
- `ech_valid` input 1: push `ech_data` this cycle.
- `res_data` input 8: adder result byte.
- `res_valid` input 1: push `res_data` this cycle.
- `tx_busy` input 1: UART transmitter busy.
- `tx_data` output 8: byte to UART; held stable from strobe until the next strobe.
- `tx_wr` output 1: one-cycle write strobe to UART.
- `ech_ovf` output 1: sticky; an echo push was dropped.
- `res_ovf` output 1: sticky; a result push was dropped.
- `idle` output 1: both FIFOs empty and FSM in IDLE.

## Operation
- Reset (`resetq`=0): FIFOs empty, FSM IDLE, `last_grant`=RES (so echo wins first), `tx_data`=0x00, `tx_wr`=0, `ech_ovf`=`res_ovf`=0, `idle`=1.
- Push: a `*_valid` pulse writes into that source's FIFO if not full. Push while full is dropped and sets the sticky `*_ovf`, even if the same cycle pops that FIFO. Both sources may push in the same cycle; each is independent.
- Order: bytes from one source leave in push order; interleaving between sources is decided by arbitration only.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `tx_busy`=0 and any FIFO non-empty → grant, pop head, register `tx_data`, assert `tx_wr` for one cycle, load busy-wait counter with `BUSY_WAIT`, → WAIT_BUSY. Otherwise stay.
  - Grant: both non-empty → source opposite to `last_grant`; one non-empty → that source. `last_grant` updates to the granted source.
  - WAIT_BUSY: `tx_busy`=1 → WAIT_DONE. Else decrement counter; on counter reaching 0 → IDLE (UART accepted without visible busy, e.g. simulation model).
  - WAIT_DONE: `tx_busy`=0 → IDLE.
- `clr`=1: FIFOs emptied, FSM → IDLE, `tx_wr`=0 next cycle, `*_ovf` cleared, `last_grant`=RES; pushes in the `clr` cycle are discarded. A byte already strobed completes inside the UART. `tx_data` keeps its value.
- `clr` has priority over push, pop and FSM transitions.

## Timing
- FIFO occupancy registered: push at edge E0 is poppable at E1; earliest `tx_wr` is the cycle after E1 (one-cycle latency from push to strobe with an idle UART).
- `tx_wr` is a registered output; never high two cycles in a row; minimum strobe spacing 2 cycles (IDLE → WAIT_BUSY → IDLE).
- `tx_wr` never asserts while `tx_busy`=1 was sampled at the granting edge.
- `idle` is combinational from registered state; `*_ovf` registered, set at the edge of the dropped push.
- FIFO pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`; count is log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- Asynchronous `resetq` mid-transfer: all state returns to reset values immediately, without waiting for a clock.

## Structure
- Shared package: FSM state enum (IDLE/WAIT_BUSY/WAIT_DONE), source-id constants (ECH=0, RES=1), defaults for `DEPTH` and `BUSY_WAIT`.
- One sub-module `byte_fifo` (parameter `DEPTH`; push/pop/clr, data out, full/empty, drop flag), instantiated twice. Arbiter and FSM live in the top.

## Test plan
- Single echo 0x41 with `tx_busy` held 0 → `tx_wr` one cycle, `tx_data`=0x41, one cycle after the push is visible; `idle` returns to 1 after `BUSY_WAIT`+1 cycles.
- Push echo 0x31,0x32 and result 0x33,0x34 in the same cycles; busy model high 10 cycles after each strobe → output order 0x31,0x33,0x32,0x34; no strobe while busy.
- Five echo pushes (0x30–0x34) with `tx_busy` stuck 1, `DEPTH`=4 → 0x34 dropped, `ech_ovf`=1, `res_ovf`=0; release busy → 0x30–0x33 sent in order.
- Push to full FIFO in the same cycle as its pop → push dropped, `ech_ovf` set, popped byte transmitted.
- `clr` while in WAIT_DONE with 3 queued bytes → next cycle FIFOs empty, FSM IDLE, flags 0, no further `tx_wr` after busy falls.
- `resetq` low mid-WAIT_BUSY, asynchronous to `clk` → `tx_wr`=0, `tx_data`=0x00, `idle`=1 before the next clock edge.
